// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - hazard detection and IF/ID / PC / ID/EX pipeline control
//
// Purpose: compares ID-stage source registers against the destinations held in
// ID/EX and EX/MEM and drives the IF/ID stall / stall_twice / flush inputs, the
// PC hold and the ID/EX bubble. A two-state FSM shadows the second cycle of the
// two-cycle hold that IF/ID performs after a stall_twice pulse. A saturating
// counter records cycles in which the PC was held.
//
// Ports:
//   clk, nReset                 clock, asynchronous active-low reset
//   id_rs1/id_rs2               ID source registers
//   id_use_rs1/id_use_rs2       ID instruction reads rs1/rs2
//   id_is_branch                ID instruction is a branch resolved in ID
//   idex_rd/idex_reg_write      ID/EX destination and write enable
//   idex_mem_read               ID/EX is a load
//   exmem_rd/exmem_mem_read     EX/MEM destination and load flag
//   branch_taken                taken branch/jump redirect this cycle
//   pc_stall                    hold PC
//   if_id_stall                 IF/ID single-cycle stall
//   if_id_stall_twice           IF/ID two-cycle hold request (one-cycle pulse)
//   if_id_flush                 IF/ID flush
//   id_ex_bubble                insert NOP into ID/EX
//   busy                        FSM is in HOLD
//   stall_count                 saturating count of PC-held cycles
module hazard_ctrl #(
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  nReset,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_use_rs1,
  input  logic                  id_use_rs2,
  input  logic                  id_is_branch,
  input  logic [REG_ADDR_W-1:0] idex_rd,
  input  logic                  idex_reg_write,
  input  logic                  idex_mem_read,
  input  logic [REG_ADDR_W-1:0] exmem_rd,
  input  logic                  exmem_mem_read,
  input  logic                  branch_taken,
  output logic                  pc_stall,
  output logic                  if_id_stall,
  output logic                  if_id_stall_twice,
  output logic                  if_id_flush,
  output logic                  id_ex_bubble,
  output logic                  busy,
  output logic [CNT_W-1:0]      stall_count
);

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic match_idex;
  logic match_exmem;
  logic haz_lb;
  logic haz_s1;

  // Register 0 is hard-wired to zero, so it never creates a dependency.
  always_comb begin
    match_idex  = (idex_rd != '0) &&
                  ((id_use_rs1 && (id_rs1 == idex_rd)) ||
                   (id_use_rs2 && (id_rs2 == idex_rd)));
    match_exmem = (exmem_rd != '0) &&
                  ((id_use_rs1 && (id_rs1 == exmem_rd)) ||
                   (id_use_rs2 && (id_rs2 == exmem_rd)));
  end

  // A load feeding a branch in ID needs two bubbles; every other hazard
  // needs one and is re-evaluated on the following cycle.
  always_comb begin
    haz_lb = id_is_branch && idex_mem_read && match_idex;
    haz_s1 = (idex_mem_read && match_idex && !id_is_branch) ||
             (id_is_branch && idex_reg_write && !idex_mem_read && match_idex) ||
             (id_is_branch && exmem_mem_read && match_exmem);
  end

  logic pc_stall_c, stall_c, twice_c, flush_c, bubble_c;

  always_comb begin
    pc_stall_c = 1'b0;
    stall_c    = 1'b0;
    twice_c    = 1'b0;
    flush_c    = 1'b0;
    bubble_c   = 1'b0;
    state_d    = IDLE;
    unique case (state_q)
      IDLE: begin
        if (branch_taken) begin
          flush_c  = 1'b1;
          bubble_c = 1'b1;
        end else if (haz_lb) begin
          twice_c    = 1'b1;
          pc_stall_c = 1'b1;
          bubble_c   = 1'b1;
          state_d    = HOLD;
        end else if (haz_s1) begin
          stall_c    = 1'b1;
          pc_stall_c = 1'b1;
          bubble_c   = 1'b1;
        end
      end
      HOLD: begin
        // IF/ID is holding on its own; a flush here also clears its counter.
        bubble_c = 1'b1;
        if (branch_taken) begin
          flush_c = 1'b1;
        end else begin
          pc_stall_c = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // While reset is asserted every control output is forced low, independent
  // of whatever the pipeline inputs happen to be.
  always_comb begin
    pc_stall          = nReset & pc_stall_c;
    if_id_stall       = nReset & stall_c;
    if_id_stall_twice = nReset & twice_c;
    if_id_flush       = nReset & flush_c;
    id_ex_bubble      = nReset & bubble_c;
    busy              = nReset & (state_q == HOLD);
    stall_count       = cnt_q;
  end

  always_comb begin
    cnt_d = cnt_q;
    if (pc_stall_c && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - directed self-checking bench for hazard_ctrl
module tb_hazard_ctrl;

  logic       clk = 1'b0;
  logic       nReset;
  logic [4:0] id_rs1, id_rs2, idex_rd, exmem_rd;
  logic       id_use_rs1, id_use_rs2, id_is_branch;
  logic       idex_reg_write, idex_mem_read, exmem_mem_read, branch_taken;
  logic       pc_stall, if_id_stall, if_id_stall_twice, if_id_flush, id_ex_bubble, busy;
  logic [15:0] stall_count;
  logic       s_pc_stall, s_stall, s_twice, s_flush, s_bubble, s_busy;
  logic [1:0] s_count;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  hazard_ctrl #(.REG_ADDR_W(5), .CNT_W(16)) u_dut (
    .clk(clk), .nReset(nReset),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .id_is_branch(id_is_branch), .idex_rd(idex_rd), .idex_reg_write(idex_reg_write),
    .idex_mem_read(idex_mem_read), .exmem_rd(exmem_rd), .exmem_mem_read(exmem_mem_read),
    .branch_taken(branch_taken),
    .pc_stall(pc_stall), .if_id_stall(if_id_stall), .if_id_stall_twice(if_id_stall_twice),
    .if_id_flush(if_id_flush), .id_ex_bubble(id_ex_bubble), .busy(busy),
    .stall_count(stall_count)
  );

  hazard_ctrl #(.REG_ADDR_W(5), .CNT_W(2)) u_dut_sat (
    .clk(clk), .nReset(nReset),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .id_is_branch(id_is_branch), .idex_rd(idex_rd), .idex_reg_write(idex_reg_write),
    .idex_mem_read(idex_mem_read), .exmem_rd(exmem_rd), .exmem_mem_read(exmem_mem_read),
    .branch_taken(branch_taken),
    .pc_stall(s_pc_stall), .if_id_stall(s_stall), .if_id_stall_twice(s_twice),
    .if_id_flush(s_flush), .id_ex_bubble(s_bubble), .busy(s_busy),
    .stall_count(s_count)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Output vector order: {pc_stall, stall, stall_twice, flush, bubble, busy}
  task automatic chk_out(input string tag, input logic [5:0] exp);
    check(tag, {26'd0, pc_stall, if_id_stall, if_id_stall_twice, if_id_flush, id_ex_bubble, busy},
          {26'd0, exp});
  endtask

  task automatic clr_in();
    id_rs1 = 0; id_rs2 = 0; id_use_rs1 = 0; id_use_rs2 = 0; id_is_branch = 0;
    idex_rd = 0; idex_reg_write = 0; idex_mem_read = 0;
    exmem_rd = 0; exmem_mem_read = 0; branch_taken = 0;
  endtask

  task automatic next_cyc();
    @(negedge clk);
  endtask

  task automatic do_reset();
    next_cyc();
    nReset = 1'b0;
    next_cyc();
    nReset = 1'b1;
  endtask

  // Load-to-branch hazard through rs2.
  task automatic set_lb();
    clr_in();
    idex_mem_read = 1; idex_reg_write = 1; idex_rd = 7;
    id_rs2 = 7; id_use_rs2 = 1; id_is_branch = 1;
  endtask

  initial begin
    clr_in();
    nReset = 1'b0;

    // 1. Reset: outputs low even with a hazard present on the inputs.
    idex_mem_read = 1; idex_rd = 5; id_rs1 = 5; id_use_rs1 = 1;
    #1;
    chk_out("reset_outs", 6'b000000);
    check("reset_count", stall_count, 0);
    next_cyc();
    clr_in();
    nReset = 1'b1;
    #1 chk_out("idle_after_reset", 6'b000000);
    next_cyc();
    #1 chk_out("idle_after_reset2", 6'b000000);

    // 2. Load-use single stall.
    idex_mem_read = 1; idex_reg_write = 1; idex_rd = 5; id_rs1 = 5; id_use_rs1 = 1;
    #1 chk_out("load_use", 6'b110010);
    next_cyc();
    clr_in();
    #1 chk_out("load_use_clear", 6'b000000);
    check("load_use_count", stall_count, 1);

    // 3. Load-to-branch two-cycle hold.
    do_reset();
    set_lb();
    #1 chk_out("lb_c0", 6'b101010);
    next_cyc();
    clr_in();
    #1 chk_out("lb_c1_hold", 6'b100011);
    next_cyc();
    #1 chk_out("lb_c2", 6'b000000);
    check("lb_count", stall_count, 2);

    // HOLD ignores hazards: keep LB asserted through the hold cycle.
    do_reset();
    set_lb();
    next_cyc();
    #1 chk_out("hold_ignores_haz", 6'b100011);
    next_cyc();
    #1 chk_out("lb_again_after_hold", 6'b101010);
    clr_in();

    // 4. rd == 0 never matches.
    do_reset();
    idex_mem_read = 1; idex_rd = 0; id_rs1 = 0; id_use_rs1 = 1;
    #1 chk_out("rd_zero", 6'b000000);
    // Source not used: no match.
    idex_rd = 9; id_rs1 = 9; id_use_rs1 = 0;
    #1 chk_out("rs1_unused", 6'b000000);
    // Branch after ALU producer in ID/EX: single stall.
    clr_in();
    id_is_branch = 1; idex_reg_write = 1; idex_rd = 3; id_rs1 = 3; id_use_rs1 = 1;
    #1 chk_out("branch_alu", 6'b110010);
    // Non-branch after ALU producer: forwarding covers it.
    id_is_branch = 0;
    #1 chk_out("alu_no_branch", 6'b000000);
    // Branch after load in EX/MEM: single stall.
    clr_in();
    id_is_branch = 1; exmem_mem_read = 1; exmem_rd = 12; id_rs2 = 12; id_use_rs2 = 1;
    #1 chk_out("branch_exmem_load", 6'b110010);
    id_is_branch = 0;
    #1 chk_out("exmem_load_no_branch", 6'b000000);
    // branch_taken beats LB in IDLE and no HOLD follows.
    set_lb();
    branch_taken = 1;
    #1 chk_out("taken_over_lb", 6'b000110);
    next_cyc();
    clr_in();
    #1 chk_out("taken_no_hold", 6'b000000);

    // 5. Flush during HOLD.
    do_reset();
    set_lb();
    #1 chk_out("flush_hold_c0", 6'b101010);
    next_cyc();
    clr_in();
    branch_taken = 1;
    #1 chk_out("flush_hold_c1", 6'b000111);
    next_cyc();
    branch_taken = 0;
    #1 chk_out("flush_hold_c2", 6'b000000);
    check("flush_hold_count", stall_count, 1);

    // Reset in the middle of HOLD.
    do_reset();
    set_lb();
    next_cyc();
    #1 chk_out("pre_reset_hold", 6'b100011);
    nReset = 1'b0;
    #1 chk_out("reset_mid_hold", 6'b000000);
    check("reset_mid_hold_count", stall_count, 0);
    next_cyc();
    nReset = 1'b1;
    clr_in();
    #1 chk_out("after_reset_mid_hold", 6'b000000);

    // 6. Saturation on the 2-bit counter instance; 16-bit keeps counting.
    do_reset();
    idex_mem_read = 1; idex_rd = 5; id_rs1 = 5; id_use_rs1 = 1;
    for (int k = 0; k < 5; k++) begin
      next_cyc();
      #1;
      check($sformatf("sat_cnt%0d", k), s_count, (k < 3) ? k + 1 : 3);
    end
    check("wide_cnt", stall_count, 5);
    clr_in();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
